// File: rtl/mw_add_seq.sv
// Multi-word sequential adder/subtractor: one 32-bit ripple-carry adder is reused
// word by word, least-significant word first, with the carry held in a register.
module rca_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic w_c;

    always_comb begin
        w_c = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        cout = w_c;
    end
endmodule

module mw_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic [1:0]            dbg_state
);
    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never depends combinationally on ready, and payload is stable while valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [31:0]     w_a_word;
    logic [31:0]     w_b_word;
    logic [31:0]     w_sum_word;
    logic            w_cout;

    // Subtraction is A + ~B + 1; the +1 is preloaded into the carry register.
    assign w_a_word = r_a[{r_idx, 5'b0} +: 32];
    assign w_b_word = r_b[{r_idx, 5'b0} +: 32] ^ {32{r_sub}};

    rca_32bit u_rca (
        .a    (w_a_word),
        .b    (w_b_word),
        .cin  (r_carry),
        .sum  (w_sum_word),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_sub      <= op_sub;
                        r_carry    <= op_sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 5'b0} +: 32] <= w_sum_word;
                    r_carry <= w_cout;
                    if (r_idx == IW'(WORDS - 1)) begin
                        r_cout      <= w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;
endmodule
